// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO result buffer between the ALU and writeback
//
// Captures each registered ALU result {result, carry, opcode} into a DEPTH-entry
// first-word-fall-through FIFO and presents the head entry over a valid/ready
// handshake. Results arriving while the FIFO is full and the consumer is not
// popping are dropped; a sticky overflow flag and a saturating counter record them.
//
// Optional feature macro: ALU_RESULT_BUFFER_FLAGS_EN
//   defined   : each entry also stores {sign, zero} of the result, shown on out_flags
//   undefined : no flag storage, out_flags tied to 2'b00
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/result/carry/opcode   incoming ALU result (no stall possible)
//   out_valid/ready                 head-entry handshake
//   out_result/carry/opcode/flags   head entry (combinational read)
//   count, full                     occupancy status
//   overflow, drop_cnt              sticky drop flag, saturating drop counter

module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [31:0]                alu_result,
    input  logic                       alu_carry,
    input  logic [3:0]                 alu_opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic                       out_carry,
    output logic [3:0]                 out_opcode,
    output logic [1:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Storage (not reset)
    logic [31:0] mem_result_q [DEPTH];
    logic        mem_carry_q  [DEPTH];
    logic [3:0]  mem_opcode_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic push;
    logic pop;
    logic drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push
    // whenever the consumer is taking the head entry.
    assign pop  = out_valid && out_ready;
    assign push = alu_valid && (!full || pop);
    assign drop = alu_valid && full && !out_ready;

    assign out_result = mem_result_q[rd_ptr_q];
    assign out_carry  = mem_carry_q[rd_ptr_q];
    assign out_opcode = mem_opcode_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_result_q[wr_ptr_q] <= alu_result;
            mem_carry_q[wr_ptr_q]  <= alu_carry;
            mem_opcode_q[wr_ptr_q] <= alu_opcode;
        end
    end

`ifdef ALU_RESULT_BUFFER_FLAGS_EN
    logic [1:0] mem_flags_q [DEPTH];

    // {sign, zero} computed once at push time
    always_ff @(posedge clk) begin
        if (push) begin
            mem_flags_q[wr_ptr_q] <= {alu_result[31], (alu_result == 32'd0)};
        end
    end

    assign out_flags = mem_flags_q[rd_ptr_q];
`else
    assign out_flags = 2'b00;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - scoreboard testbench for alu_result_buffer

module tb_alu_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic [3:0]  alu_opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_carry;
    logic [3:0]  out_opcode;
    logic [1:0]  out_flags;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic [3:0]  op;
    } ent_t;

    ent_t exp_q[$];

    alu_result_buffer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_opcode (alu_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_flags(input logic [31:0] r);
`ifdef ALU_RESULT_BUFFER_FLAGS_EN
        return {r[31], (r == 32'd0)};
`else
        return 2'b00;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h expected none", out_result);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("pop_result", out_result, e.r);
                chk("pop_carry",  {31'd0, out_carry}, {31'd0, e.c});
                chk("pop_opcode", {28'd0, out_opcode}, {28'd0, e.op});
                chk("pop_flags",  {30'd0, out_flags}, {30'd0, exp_flags(e.r)});
            end
        end
    end

    // One clock with a push presented; accept says whether the bench expects it stored
    task automatic push_cycle(input logic [31:0] r, input logic c, input logic [3:0] op,
                              input logic rdy, input logic accept);
        alu_valid  = 1'b1;
        alu_result = r;
        alu_carry  = c;
        alu_opcode = op;
        out_ready  = rdy;
        if (accept) exp_q.push_back('{r: r, c: c, op: op});
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        alu_valid = 1'b0;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        alu_valid  = 1'b0;
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_opcode = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_count",    {29'd0, count}, 32'd0);
        chk("rst_full",     {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop",     {24'd0, drop_cnt}, 32'd0);

        // Single push, visible one cycle later
        push_cycle(32'h0000_0005, 1'b1, 4'b0000, 1'b0, 1'b1);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_count", {29'd0, count}, 32'd1);
        chk("single_head",  out_result, 32'h5);
        chk("single_carry", {31'd0, out_carry}, 32'd1);
        chk("single_flags", {30'd0, out_flags}, 32'd0);
        idle(1'b1);
        chk("single_drained", {29'd0, count}, 32'd0);

        // Fill to full
        for (int i = 1; i <= 4; i++) push_cycle(32'(i), 1'b0, 4'(i), 1'b0, 1'b1);
        chk("fill_full",  {31'd0, full}, 32'd1);
        chk("fill_count", {29'd0, count}, 32'd4);

        // Drops while full and stalled
        for (int i = 0; i < 3; i++) push_cycle(32'hDEAD_0000 + 32'(i), 1'b1, 4'hF, 1'b0, 1'b0);
        chk("drop_overflow", {31'd0, overflow}, 32'd1);
        chk("drop_cnt3",     {24'd0, drop_cnt}, 32'd3);
        chk("drop_count",    {29'd0, count}, 32'd4);
        chk("drop_head",     out_result, 32'd1);

        // Full with simultaneous pop: push accepted
        push_cycle(32'h0000_0055, 1'b0, 4'd9, 1'b1, 1'b1);
        chk("fullpp_count", {29'd0, count}, 32'd4);
        chk("fullpp_full",  {31'd0, full}, 32'd1);
        chk("fullpp_drop",  {24'd0, drop_cnt}, 32'd3);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_count", {29'd0, count}, 32'd0);
        chk("drain_full",  {31'd0, full}, 32'd0);

        // Flag patterns: zero and sign
        push_cycle(32'h0000_0000, 1'b0, 4'd2, 1'b1, 1'b1);
        push_cycle(32'h8000_0000, 1'b1, 4'd3, 1'b1, 1'b1);
        idle(1'b1);
        chk("sticky_overflow", {31'd0, overflow}, 32'd1);
        chk("sticky_drop",     {24'd0, drop_cnt}, 32'd3);

        // Reset to clear overflow state before the streaming test
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_overflow", {31'd0, overflow}, 32'd0);
        chk("rst2_drop",     {24'd0, drop_cnt}, 32'd0);

        // Streaming with out_ready high: pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            push_cycle(32'd100 + 32'(i), 1'(i), 4'(i), 1'b1, 1'b1);
            chk("stream_count_le1", {31'd0, (count <= 3'd1)}, 32'd1);
        end
        idle(1'b1);
        idle(1'b0);
        chk("stream_drop",  {24'd0, drop_cnt}, 32'd0);
        chk("stream_count", {29'd0, count}, 32'd0);
        chk("stream_all_popped", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) push_cycle(32'd200 + 32'(i), 1'b0, 4'd1, 1'b0, 1'b1);
        chk("burst_count", {29'd0, count}, 32'd3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid",    {31'd0, out_valid}, 32'd0);
        chk("arst_count",    {29'd0, count}, 32'd0);
        chk("arst_full",     {31'd0, full}, 32'd0);
        chk("arst_overflow", {31'd0, overflow}, 32'd0);
        chk("arst_drop",     {24'd0, drop_cnt}, 32'd0);
        #2;
        rst_n = 1'b1;
        push_cycle(32'h0000_0077, 1'b1, 4'd5, 1'b0, 1'b1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_count", {29'd0, count}, 32'd1);
        chk("post_rst_head",  out_result, 32'h77);
        idle(1'b1);
        idle(1'b0);
        chk("final_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count", {29'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
